// File: rtl/cmac_axil_pkg.sv
// Shared types and constants for the CMAC AXI4-Lite configuration-port arbiter.
package cmac_axil_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [31:0] CFG_TX_REG1 = 32'h0000_000C;
    localparam logic [31:0] CFG_RX_REG1 = 32'h0000_0014;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // EXOKAY has no meaning on AXI4-Lite, so anything but OKAY is an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/cmac_rr_arbiter.sv
// Combinational round-robin grant: first asserted request searching upward from last+1.
module cmac_rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] k;

    // last < N and offset <= N, so one conditional subtract is a full mod N.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        k     = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, last} + (IW+1)'(i);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            k = sum[IW-1:0];
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/cmac_axil_arbiter.sv
// Serializes single-beat register reads/writes from NUM_REQ requesters onto one
// AXI4-Lite master, one outstanding transaction, with a recovery timeout.
module cmac_axil_arbiter
    import cmac_axil_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_sreset,

    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,

    output logic [31:0]             m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [31:0]             m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                         state;
    logic [IW-1:0]                  last;
    logic [IW-1:0]                  gidx;
    cmd_t                           cmd;
    cmd_t                           sel;
    logic [31:0]                    rdata_q;
    logic                           err_q;
    logic [CW-1:0]                  tcnt;

    logic [NUM_REQ-1:0][31:0]       addr_arr;
    logic [NUM_REQ-1:0][31:0]       wdata_arr;
    logic [NUM_REQ-1:0]             gnt;
    logic [IW-1:0]                  gnt_idx;
    logic                           gnt_any;
    logic                           busy;
    logic                           expired;
    logic                           aw_left;
    logic                           w_left;

    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;

    cmac_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .last  (last),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    always_comb begin
        sel.write = req_write[gnt_idx];
        sel.addr  = addr_arr[gnt_idx];
        sel.wdata = wdata_arr[gnt_idx];
    end

    assign req_ready = (state == IDLE) ? gnt : '0;

    assign busy    = (state != IDLE) && (state != RESP);
    assign expired = busy && (tcnt == CW'(TIMEOUT_CYCLES - 1));
    assign aw_left = m_axi_awvalid && !m_axi_awready;
    assign w_left  = m_axi_wvalid  && !m_axi_wready;

    assign m_axi_awaddr = cmd.addr;
    assign m_axi_araddr = cmd.addr;
    assign m_axi_wdata  = cmd.wdata;
    assign m_axi_wstrb  = 4'hF;

    // Response fields are only presented during RESP; writes never carry read data.
    assign rsp_valid = (state == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gidx) : '0;
    assign rsp_rdata = (state == RESP && !cmd.write) ? rdata_q : '0;
    assign rsp_err   = (state == RESP) ? err_q : 1'b0;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_sreset) begin
            state         <= IDLE;
            last          <= IW'(NUM_REQ - 1);
            gidx          <= '0;
            cmd           <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            tcnt          <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        gidx    <= gnt_idx;
                        last    <= gnt_idx;
                        cmd     <= sel;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        tcnt    <= '0;
                        if (sel.write) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_ADDR_DATA;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (m_axi_awready)
                        m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)
                        m_axi_wvalid <= 1'b0;
                    if (!aw_left && !w_left) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        err_q        <= resp_is_err(m_axi_bresp);
                        state        <= RESP;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rdata_q      <= m_axi_rdata;
                        err_q        <= resp_is_err(m_axi_rresp);
                        state        <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Timeout overrides any completion landing in the same cycle.
            if (busy) begin
                tcnt <= tcnt + 1'b1;
                if (expired) begin
                    m_axi_awvalid <= 1'b0;
                    m_axi_wvalid  <= 1'b0;
                    m_axi_bready  <= 1'b0;
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b0;
                    err_q         <= 1'b1;
                    rdata_q       <= '0;
                    state         <= RESP;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmac_axil_arbiter.sv
// Directed + randomized bench for cmac_axil_arbiter with a configurable AXI4-Lite slave.
module tb_cmac_axil_arbiter;
    import cmac_axil_pkg::*;

    localparam int N  = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]       req_valid, req_ready, req_write, rsp_valid;
    logic [N-1:0][31:0] req_addr, req_wdata;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic [31:0]        awaddr, wdata, araddr, rdata;
    logic [3:0]         wstrb;
    logic               awvalid, awready, wvalid, wready, bvalid, bready;
    logic               arvalid, arready, rvalid, rready;
    logic [1:0]         bresp, rresp;

    cmac_axil_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .m_axi_aclk(clk), .m_axi_sreset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int tests = 0;
    int fails = 0;
    int mlast;

    // slave configuration and observations
    int          aw_d, w_d, ar_d;
    logic [1:0]  bresp_c, rresp_c;
    logic [31:0] rdata_c;
    bit          b_never;
    logic [31:0] rec_awaddr, rec_wdata, rec_araddr;
    logic [3:0]  rec_wstrb;
    int          n_aw, n_w, n_ar, n_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++)
            if (((mask >> ((last + k) % N)) & 1) != 0)
                return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Slave: ready after a per-channel delay, response the cycle after the last handshake.
    initial begin
        bit s_aw, s_w, s_b, s_ar, s_r, aw_got, w_got, ar_got;
        int aw_c, w_c, ar_c;
        s_aw = 0; s_w = 0; s_b = 0; s_ar = 0; s_r = 0;
        aw_got = 0; w_got = 0; ar_got = 0; aw_c = 0; w_c = 0; ar_c = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_got = 0; w_got = 0; ar_got = 0; aw_c = 0; w_c = 0; ar_c = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            end else begin
                if (s_aw) begin awready = 0; aw_got = 1; aw_c = 0; end
                if (s_w)  begin wready  = 0; w_got  = 1; w_c  = 0; end
                if (s_ar) begin arready = 0; ar_got = 1; ar_c = 0; end
                if (s_b) bvalid = 0;
                if (s_r) rvalid = 0;
                if (awvalid && !awready) begin if (aw_c >= aw_d) awready = 1; else aw_c++; end
                if (wvalid  && !wready)  begin if (w_c  >= w_d)  wready  = 1; else w_c++;  end
                if (arvalid && !arready) begin if (ar_c >= ar_d) arready = 1; else ar_c++; end
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0;
                    if (!b_never) begin bvalid = 1; bresp = bresp_c; end
                end
                if (ar_got) begin
                    ar_got = 0; rvalid = 1; rdata = rdata_c; rresp = rresp_c;
                end
            end
            s_aw = awvalid && awready;
            s_w  = wvalid && wready;
            s_ar = arvalid && arready;
            s_b  = bvalid && bready;
            s_r  = rvalid && rready;
            if (s_aw) rec_awaddr = awaddr;
            if (s_w)  begin rec_wdata = wdata; rec_wstrb = wstrb; end
            if (s_ar) rec_araddr = araddr;
        end
    end

    // One command from the requesters in mask; expectations come from the model.
    task automatic txn(input string tag, input logic [N-1:0] mask, input bit to_exp);
        int g, cyc, lat;
        logic [31:0] er;
        logic ee;
        g = model_grant(mask, mlast);
        if (req_write[g]) lat = 3 + ((aw_d > w_d) ? aw_d : w_d);
        else              lat = 3 + ar_d;
        if (to_exp) lat = TO + 1;
        er = (to_exp || req_write[g]) ? 32'h0 : rdata_c;
        ee = to_exp ? 1'b1 : (req_write[g] ? (bresp_c != 2'b00) : (rresp_c != 2'b00));
        @(negedge clk);
        req_valid = mask;
        #1;
        check({tag, "/ready"}, 32'(req_ready), 32'(oh(g)));
        rec_awaddr = 'x; rec_wdata = 'x; rec_wstrb = 'x; rec_araddr = 'x;
        n_aw = 0; n_w = 0; n_ar = 0; n_b = 0;
        @(negedge clk);
        req_valid = '0;
        cyc = 1;
        while (rsp_valid == '0 && cyc < 200) begin
            n_aw += int'(awvalid); n_w += int'(wvalid); n_ar += int'(arvalid); n_b += int'(bready);
            @(negedge clk);
            cyc++;
        end
        check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'(oh(g)));
        check({tag, "/latency"}, cyc, lat);
        check({tag, "/rdata"}, rsp_rdata, er);
        check({tag, "/err"}, 32'(rsp_err), 32'(ee));
        check({tag, "/idle_bus"}, {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
        if (!to_exp) begin
            if (req_write[g]) begin
                check({tag, "/awaddr"}, rec_awaddr, req_addr[g]);
                check({tag, "/wdata"}, rec_wdata, req_wdata[g]);
                check({tag, "/wstrb"}, 32'(rec_wstrb), 32'hF);
            end else begin
                check({tag, "/araddr"}, rec_araddr, req_addr[g]);
            end
        end
        mlast = g;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, nrsp, g;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        aw_d = 0; w_d = 0; ar_d = 0; bresp_c = 2'b00; rresp_c = 2'b00;
        rdata_c = 32'h0; b_never = 0;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst/valids", {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
        check("rst/rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst/rsp_err", 32'(rsp_err), 32'h0);
        check("rst/rsp_rdata", rsp_rdata, 32'h0);
        check("rst/awaddr", awaddr, 32'h0);
        check("rst/araddr", araddr, 32'h0);
        check("rst/wdata", wdata, 32'h0);
        rst = 1'b0;
        mlast = N - 1;

        // zero-wait write from requester 0
        req_write[0] = 1'b1; req_addr[0] = CFG_RX_REG1; req_wdata[0] = 32'h1;
        txn("wr0", 3'b001, 0);

        // read with arready delayed five cycles
        req_write[1] = 1'b0; req_addr[1] = 32'h200; ar_d = 5; rdata_c = 32'hDEADBEEF;
        txn("rd1", 3'b010, 0);
        check("rd1/arvalid_cycles", n_ar, 6);
        ar_d = 0;

        // AW completes three cycles before W, slave returns SLVERR
        req_write[2] = 1'b1; req_addr[2] = CFG_TX_REG1; req_wdata[2] = $urandom;
        w_d = 3; bresp_c = AXI_RESP_SLVERR;
        txn("wr2_err", 3'b100, 0);
        check("wr2_err/awvalid_cycles", n_aw, 1);
        check("wr2_err/wvalid_cycles", n_w, 4);
        w_d = 0; bresp_c = AXI_RESP_OKAY;

        // slave never answers B -> timeout, then a normal transaction
        b_never = 1; req_write[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = $urandom;
        txn("timeout", 3'b001, 1);
        check("timeout/bready_cycles", n_b, TO - 1);
        b_never = 0;
        req_write[1] = 1'b0; req_addr[1] = 32'h80; rdata_c = $urandom;
        txn("after_timeout", 3'b010, 0);

        // reset while waiting in WR_RESP
        b_never = 1; req_write[2] = 1'b1; req_addr[2] = 32'h100; req_wdata[2] = $urandom;
        g = model_grant(3'b100, mlast);
        @(negedge clk);
        req_valid = 3'b100;
        #1;
        check("rst_mid/ready", 32'(req_ready), 32'(oh(g)));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("rst_mid/in_wr_resp", 32'(bready), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid/valids", {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
        check("rst_mid/rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid/awaddr", awaddr, 32'h0);
        rst = 1'b0;
        b_never = 0;
        mlast = N - 1;
        nrsp = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid != '0) nrsp++;
        end
        check("rst_mid/no_rsp", nrsp, 0);

        // all requesters continuously valid: order 0,1,2,0,1,2,...
        req_write = N'($urandom);
        for (int i = 0; i < N; i++) begin
            req_addr[i] = $urandom & 32'hFFFF_FFFC;
            req_wdata[i] = $urandom;
        end
        rdata_c = $urandom;
        @(negedge clk);
        req_valid = '1;
        #1;
        for (int n = 0; n < 9; n++) begin
            c = 0;
            while (req_ready == '0 && c < 50) begin @(negedge clk); c++; end
            check($sformatf("fair%0d/grant", n), 32'(req_ready), 32'(oh(n % N)));
            @(negedge clk);
            c = 0;
            while (rsp_valid == '0 && c < 50) begin @(negedge clk); c++; end
            check($sformatf("fair%0d/rsp_valid", n), 32'(rsp_valid), 32'(oh(n % N)));
            check($sformatf("fair%0d/rdata", n), rsp_rdata, req_write[n % N] ? 32'h0 : rdata_c);
            mlast = n % N;
        end
        req_valid = '0;

        // randomized commands, masks, slave delays and response codes
        for (int it = 0; it < 25; it++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            req_write = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_addr[i] = $urandom & 32'hFFFF_FFFC;
                req_wdata[i] = $urandom;
            end
            aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); ar_d = $urandom_range(0, 3);
            bresp_c = 2'($urandom_range(0, 3)); rresp_c = 2'($urandom_range(0, 3));
            rdata_c = $urandom;
            txn($sformatf("rnd%0d", it), mask, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
